// File: rtl/dvp_capture.sv
// DVP sensor capture front end: registers the sensor pins, assembles multi-beat pixels,
// applies a per-frame crop window and frame-skip decimation, and emits a marked pixel stream.
module dvp_capture #(
  parameter int DATA_W          = 8,
  parameter int BYTES_PER_PIXEL = 2,
  parameter int COORD_W         = 12,
  parameter int VSYNC_POL       = 1
) (
  input  logic                               clk,
  input  logic                               rest_n,
  input  logic                               enable,
  input  logic                               vsync,
  input  logic                               href,
  input  logic [DATA_W-1:0]                  data,
  input  logic [COORD_W-1:0]                 crop_x0,
  input  logic [COORD_W-1:0]                 crop_y0,
  input  logic [COORD_W-1:0]                 crop_w,
  input  logic [COORD_W-1:0]                 crop_h,
  input  logic [3:0]                         skip_n,
  input  logic                               byte_swap,
  output logic                               out_valid,
  output logic [DATA_W*BYTES_PER_PIXEL-1:0]  out_data,
  output logic                               out_sof,
  output logic                               out_eol,
  output logic                               frame_start,
  output logic                               frame_done,
  output logic [15:0]                        frame_cnt,
  output logic                               line_err,
  output logic [1:0]                         dbg_state
);

  localparam int   PW     = DATA_W * BYTES_PER_PIXEL;
  localparam int   BW     = (BYTES_PER_PIXEL > 1) ? $clog2(BYTES_PER_PIXEL) : 1;
  localparam int   CW1    = COORD_W + 1;
  localparam logic VS_ACT = (VSYNC_POL != 0);

  typedef enum logic [1:0] {IDLE = 2'd0, CAPTURE = 2'd1, SKIP = 2'd2} state_t;

  // out_valid is a one-cycle strobe with no ready: the downstream writer must take every
  // beat on which out_valid is high; out_sof/out_eol/frame_done qualify that same beat.
  state_t               state;
  logic                 vs_r, vs_q, hr_r, hr_q;
  logic [DATA_W-1:0]    d_r;
  logic [BW-1:0]        beat;
  logic [COORD_W-1:0]   x, y;
  logic [3:0]           skip_cnt;
  logic [COORD_W-1:0]   cx0, cy0, cw, ch;
  logic                 swap_l;
  logic [PW-1:0]        acc, pix_next;

  logic                 fs_evt, vs_active, href_fall, last_beat, pix_done;
  logic                 in_win, x_last, y_last;
  logic [BW-1:0]        slot;
  logic [CW1-1:0]       x_e, y_e, x_lo, y_lo, x_hi, y_hi;

  assign dbg_state = state;

  assign vs_active = (vs_r == VS_ACT);
  assign fs_evt    = (vs_q == VS_ACT) && !vs_active;
  assign href_fall = hr_q && !hr_r;
  assign last_beat = (beat == BW'(BYTES_PER_PIXEL - 1));
  assign pix_done  = hr_r && last_beat;

  // Window bounds are widened by one bit so x0+w cannot wrap.
  assign x_e    = {1'b0, x};
  assign y_e    = {1'b0, y};
  assign x_lo   = {1'b0, cx0};
  assign y_lo   = {1'b0, cy0};
  assign x_hi   = {1'b0, cx0} + {1'b0, cw};
  assign y_hi   = {1'b0, cy0} + {1'b0, ch};
  assign in_win = (x_e >= x_lo) && (x_e < x_hi) && (y_e >= y_lo) && (y_e < y_hi);
  assign x_last = (x_e == x_hi - CW1'(1));
  assign y_last = (y_e == y_hi - CW1'(1));

  // Beat k lands in byte slot k (swapped) or BYTES_PER_PIXEL-1-k (first beat is MSB).
  assign slot = swap_l ? beat : BW'(BYTES_PER_PIXEL - 1) - beat;

  always_comb begin
    pix_next = acc;
    pix_next[slot*DATA_W +: DATA_W] = d_r;
  end

  always_ff @(posedge clk or negedge rest_n) begin
    if (!rest_n) begin
      state       <= IDLE;
      vs_r        <= ~VS_ACT;
      vs_q        <= ~VS_ACT;
      hr_r        <= 1'b0;
      hr_q        <= 1'b0;
      d_r         <= '0;
      beat        <= '0;
      x           <= '0;
      y           <= '0;
      skip_cnt    <= '0;
      cx0         <= '0;
      cy0         <= '0;
      cw          <= '0;
      ch          <= '0;
      swap_l      <= 1'b0;
      acc         <= '0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_sof     <= 1'b0;
      out_eol     <= 1'b0;
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
      frame_cnt   <= '0;
      line_err    <= 1'b0;
    end else begin
      out_valid   <= 1'b0;
      out_sof     <= 1'b0;
      out_eol     <= 1'b0;
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
      line_err    <= 1'b0;

      vs_r <= vsync;
      vs_q <= vs_r;
      hr_r <= href;
      hr_q <= hr_r;
      d_r  <= data;

      if (hr_r) begin
        beat <= last_beat ? '0 : beat + BW'(1);
        acc  <= pix_next;
      end else begin
        beat <= '0;
      end

      if (fs_evt) begin
        x <= '0;
        y <= '0;
      end else if (href_fall) begin
        x <= '0;
        if (y != '1) y <= y + COORD_W'(1);
      end else if (pix_done && x != '1) begin
        x <= x + COORD_W'(1);
      end

      if (href_fall && beat != '0 && state != IDLE) line_err <= 1'b1;

      if (fs_evt) begin
        frame_start <= 1'b1;
        cx0         <= crop_x0;
        cy0         <= crop_y0;
        cw          <= crop_w;
        ch          <= crop_h;
        swap_l      <= byte_swap;
        if (enable && skip_cnt == '0) begin
          state    <= CAPTURE;
          skip_cnt <= skip_n;
        end else begin
          state <= SKIP;
          if (skip_cnt != '0) skip_cnt <= skip_cnt - 4'd1;
        end
      end else if (vs_active && state != IDLE) begin
        // An unfinished window is simply abandoned; no done pulse, no count.
        state <= IDLE;
      end else if (state == CAPTURE && pix_done && in_win) begin
        out_valid <= 1'b1;
        out_data  <= pix_next;
        out_sof   <= (x == cx0) && (y == cy0);
        out_eol   <= x_last;
        if (x_last && y_last) begin
          frame_done <= 1'b1;
          frame_cnt  <= frame_cnt + 16'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_dvp_capture.sv
// Bench for dvp_capture: drives DVP frames, predicts each window pixel with its arrival
// cycle into an expected queue, and checks frame-level counters per scenario.
module tb_dvp_capture;

  localparam int DW = 8;
  localparam int BPP = 2;
  localparam int CW = 12;
  localparam int PW = DW * BPP;
  localparam int EW = 16 + PW + 3;

  logic          clk = 1'b0;
  logic          rest_n, enable, vsync, href, byte_swap;
  logic [DW-1:0] data;
  logic [CW-1:0] crop_x0, crop_y0, crop_w, crop_h;
  logic [3:0]    skip_n;
  logic          out_valid, out_sof, out_eol, frame_start, frame_done, line_err;
  logic [PW-1:0] out_data;
  logic [15:0]   frame_cnt;
  logic [1:0]    dbg_state;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int fs_cnt = 0, le_cnt = 0, done_cnt = 0, vld_cnt = 0;
  logic [EW-1:0] exp_q[$];
  int w_x0, w_y0, w_cw, w_ch;
  logic [7:0] dbyte;

  dvp_capture #(.DATA_W(DW), .BYTES_PER_PIXEL(BPP), .COORD_W(CW), .VSYNC_POL(1)) dut (
    .clk(clk), .rest_n(rest_n), .enable(enable), .vsync(vsync), .href(href), .data(data),
    .crop_x0(crop_x0), .crop_y0(crop_y0), .crop_w(crop_w), .crop_h(crop_h),
    .skip_n(skip_n), .byte_swap(byte_swap), .out_valid(out_valid), .out_data(out_data),
    .out_sof(out_sof), .out_eol(out_eol), .frame_start(frame_start), .frame_done(frame_done),
    .frame_cnt(frame_cnt), .line_err(line_err), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  // Scoreboard side: every out_valid must match the head of exp_q, including its cycle.
  task automatic monitor_loop();
    logic [EW-1:0] got, e;
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
      #1;
      if (rest_n) begin
        if (frame_start) fs_cnt++;
        if (line_err) le_cnt++;
        if (frame_done) begin
          done_cnt++;
          checks++;
          if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL done_without_valid: out_valid=%b required 1 at cycle %0d", out_valid, cyc);
          end
        end
        if (out_valid) begin
          vld_cnt++;
          got = {16'(cyc), out_data, out_sof, out_eol, frame_done};
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_pixel: got %h with nothing expected", got);
          end else begin
            e = exp_q.pop_front();
            if (got !== e) begin
              errors++;
              $display("FAIL pixel: got {cyc,data,sof,eol,done}=%h required %h", got, e);
            end
          end
        end
      end
    end
  endtask

  task automatic push_pixel(input int px, input int ly, input logic [7:0] b0, input logic [7:0] b1);
    logic [PW-1:0] pix;
    logic          sof, eol, done;
    logic [15:0]   c;
    if (px >= w_x0 && px < w_x0 + w_cw && ly >= w_y0 && ly < w_y0 + w_ch) begin
      pix  = byte_swap ? {b1, b0} : {b0, b1};
      sof  = (px == w_x0) && (ly == w_y0);
      eol  = (px == w_x0 + w_cw - 1);
      done = eol && (ly == w_y0 + w_ch - 1);
      c    = 16'(cyc + 2);
      exp_q.push_back({c, pix, sof, eol, done});
    end
  endtask

  task automatic drive_beats(input int n, input int ly, input bit cap);
    logic [7:0] b0;
    b0 = '0;
    for (int b = 0; b < n; b++) begin
      @(negedge clk);
      href = 1'b1;
      data = dbyte;
      if (b % 2 == 0) b0 = dbyte;
      else if (cap) push_pixel(b / 2, ly, b0, dbyte);
      dbyte = dbyte + 8'd1;
    end
  endtask

  task automatic send_line(input int nbeats, input int ly, input bit cap);
    drive_beats(nbeats, ly, cap);
    @(negedge clk);
    href = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic start_frame(input bit en_after);
    @(negedge clk);
    vsync = 1'b1;
    repeat (3) @(negedge clk);
    vsync = 1'b0;
    w_x0 = int'(crop_x0);
    w_y0 = int'(crop_y0);
    w_cw = int'(crop_w);
    w_ch = int'(crop_h);
    repeat (2) @(negedge clk);
    enable = en_after;
    dbyte = 8'h01;
  endtask

  task automatic end_frame();
    @(negedge clk);
    vsync = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic send_frame(input int npix, input int nlines, input bit cap, input bit en_after);
    start_frame(en_after);
    for (int ly = 0; ly < nlines; ly++) send_line(npix * BPP, ly, cap);
    end_frame();
  endtask

  task automatic set_window(input int x0, input int y0, input int w, input int h);
    crop_x0 = CW'(x0);
    crop_y0 = CW'(y0);
    crop_w  = CW'(w);
    crop_h  = CW'(h);
  endtask

  task automatic check_int(input string name, input int got, input int req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", name, got, req);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({out_valid, out_data, out_sof, out_eol, frame_start, frame_done, frame_cnt, line_err, dbg_state} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: valid=%b data=%h fcnt=%h state=%0d required all 0",
               out_valid, out_data, frame_cnt, dbg_state);
    end
    rest_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic();
    set_window(0, 0, 4, 2);
    send_frame(4, 2, 1'b1, 1'b1);
    check_int("basic_frame_cnt", int'(frame_cnt), 1);
    check_int("basic_frame_start", fs_cnt, 1);
    check_int("basic_done", done_cnt, 1);
    check_int("basic_line_err", le_cnt, 0);
    check_int("basic_queue", exp_q.size(), 0);
  endtask

  task automatic test_swap();
    int v0;
    v0 = vld_cnt;
    byte_swap = 1'b1;
    send_frame(4, 2, 1'b1, 1'b1);
    byte_swap = 1'b0;
    check_int("swap_pixels", vld_cnt - v0, 8);
    check_int("swap_queue", exp_q.size(), 0);
  endtask

  task automatic test_crop();
    int v0, d0;
    v0 = vld_cnt;
    d0 = done_cnt;
    set_window(100, 50, 16, 4);
    send_frame(640, 54, 1'b1, 1'b1);
    check_int("crop_pixels", vld_cnt - v0, 64);
    check_int("crop_done", done_cnt - d0, 1);
    check_int("crop_frame_cnt", int'(frame_cnt), 3);
    check_int("crop_queue", exp_q.size(), 0);
  endtask

  task automatic test_skip();
    int f0, c0;
    f0 = fs_cnt;
    c0 = int'(frame_cnt);
    set_window(0, 0, 4, 2);
    skip_n = 4'd2;
    for (int f = 0; f < 6; f++) send_frame(4, 2, (f == 0 || f == 3), 1'b1);
    skip_n = 4'd0;
    check_int("skip_frame_start", fs_cnt - f0, 6);
    check_int("skip_frame_cnt", int'(frame_cnt) - c0, 2);
    check_int("skip_queue", exp_q.size(), 0);
  endtask

  task automatic test_enable();
    int c0, f0;
    c0 = int'(frame_cnt);
    f0 = fs_cnt;
    enable = 1'b0;
    send_frame(4, 2, 1'b0, 1'b1);
    check_int("enable_off_frame_cnt", int'(frame_cnt) - c0, 0);
    send_frame(4, 2, 1'b1, 1'b1);
    check_int("enable_on_frame_cnt", int'(frame_cnt) - c0, 1);
    check_int("enable_frame_start", fs_cnt - f0, 2);
    check_int("enable_queue", exp_q.size(), 0);
  endtask

  task automatic test_line_err_abort();
    int c0, l0, d0;
    c0 = int'(frame_cnt);
    l0 = le_cnt;
    d0 = done_cnt;
    set_window(0, 0, 4, 2);
    start_frame(1'b1);
    send_line(5, 0, 1'b1);
    end_frame();
    check_int("line_err_pulses", le_cnt - l0, 1);
    check_int("abort_no_done", done_cnt - d0, 0);
    check_int("abort_frame_cnt", int'(frame_cnt) - c0, 0);
    check_int("abort_queue", exp_q.size(), 0);
  endtask

  task automatic test_reset_mid_line();
    int l0, d0, f0;
    set_window(0, 0, 4, 2);
    start_frame(1'b1);
    drive_beats(4, 0, 1'b1);
    drive_beats(1, 0, 1'b0);
    @(negedge clk);
    rest_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, out_data, out_sof, out_eol, frame_start, frame_done, frame_cnt, line_err} !== '0) begin
      errors++;
      $display("FAIL mid_reset_outputs: valid=%b data=%h fcnt=%h lerr=%b required all 0",
               out_valid, out_data, frame_cnt, line_err);
    end
    l0 = le_cnt;
    d0 = done_cnt;
    f0 = fs_cnt;
    drive_beats(2, 0, 1'b0);
    rest_n = 1'b1;
    drive_beats(6, 0, 1'b0);
    @(negedge clk);
    href = 1'b0;
    repeat (3) @(negedge clk);
    send_line(8, 1, 1'b0);
    check_int("post_reset_line_err", le_cnt - l0, 0);
    check_int("post_reset_done", done_cnt - d0, 0);
    check_int("post_reset_frame_start", fs_cnt - f0, 0);
    check_int("post_reset_frame_cnt", int'(frame_cnt), 0);
    send_frame(4, 2, 1'b1, 1'b1);
    check_int("after_reset_frame_cnt", int'(frame_cnt), 1);
    check_int("after_reset_queue", exp_q.size(), 0);
  endtask

  initial begin
    rest_n    = 1'b0;
    enable    = 1'b1;
    vsync     = 1'b0;
    href      = 1'b0;
    data      = '0;
    byte_swap = 1'b0;
    skip_n    = 4'd0;
    dbyte     = 8'h01;
    set_window(0, 0, 4, 2);
    fork
      monitor_loop();
    join_none
    test_reset();
    test_basic();
    test_swap();
    test_crop();
    test_skip();
    test_enable();
    test_line_err_abort();
    test_reset_mid_line();
    repeat (4) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
